// File: rtl/param_bus_arbiter_pkg.sv
// Shared types and helpers for the parametrised single-wire bus arbiter.
package bus_arb_pkg;

    localparam int MID_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        ADDR    = 3'd2,
        CHECK   = 3'd3,
        XFER    = 3'd4,
        RELEASE = 3'd5
    } arb_state_e;

    // Lowest set bit wins; an all-zero vector maps to 0.
    function automatic logic [MID_W-1:0] onehot_to_idx(input logic [2**MID_W-1:0] vec);
        logic [MID_W-1:0] idx;
        idx = '0;
        for (int i = 2**MID_W - 1; i >= 0; i--) begin
            if (vec[i]) idx = MID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/param_bus_arbiter_if.sv
// Request/grant, serial bus snoop and slave select signals of the arbiter.
interface param_bus_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 12,
    parameter int NUM_SLAVES  = 6,
    parameter int SID_W       = 3
);
    logic [NUM_MASTERS-1:0] m_reqs;
    logic [NUM_MASTERS-1:0] m_grants;
    logic                   b_bus_utilizing;
    logic                   b_BUS;
    logic [NUM_SLAVES-1:0]  slaves_busy;
    logic [NUM_SLAVES-1:0]  slaves_sel;
    logic [MID_W-1:0]       mid_current;
    logic [SID_W-1:0]       sid_current;
    logic [2:0]             state;
    logic                   timeout_evt;

    // Bus agents: requesters, the serial line and the slave busy flags.
    modport master (
        output m_reqs, b_bus_utilizing, b_BUS, slaves_busy,
        input  m_grants, slaves_sel, mid_current, sid_current, state, timeout_evt
    );

    // The arbiter itself.
    modport slave (
        input  m_reqs, b_bus_utilizing, b_BUS, slaves_busy,
        output m_grants, slaves_sel, mid_current, sid_current, state, timeout_evt
    );
endinterface

// File: rtl/param_bus_arbiter_arb_rr_picker.sv
// Combinational winner selection: rotate by the pointer, priority-encode, un-rotate.
module arb_rr_picker
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 12
) (
    input  logic [NUM_MASTERS-1:0] i_eligible,
    input  logic [MID_W-1:0]       i_ptr,
    input  logic                   i_arb_rr,
    output logic [MID_W-1:0]       o_winner,
    output logic                   o_valid
);
    logic [MID_W-1:0]       w_ptr;
    logic [NUM_MASTERS-1:0] w_rotated;
    logic [MID_W-1:0]       w_rot_idx;
    logic [MID_W:0]         w_sum;

    // Fixed priority is round-robin with the pointer pinned at 0.
    assign w_ptr     = i_arb_rr ? i_ptr : '0;
    assign w_rotated = NUM_MASTERS'({i_eligible, i_eligible} >> w_ptr);

    always_comb begin
        w_rot_idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_rotated[i]) w_rot_idx = MID_W'(i);
        end
    end

    assign w_sum    = {1'b0, w_rot_idx} + {1'b0, w_ptr};
    assign o_winner = (w_sum >= (MID_W+1)'(NUM_MASTERS)) ?
                      MID_W'(w_sum - (MID_W+1)'(NUM_MASTERS)) : w_sum[MID_W-1:0];
    assign o_valid  = |i_eligible;

endmodule

// File: rtl/param_bus_arbiter.sv
// Bus arbiter: grant FSM, serial slave-ID snoop, watchdogs and per-master retry holdoff.
module param_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS   = 12,
    parameter int NUM_SLAVES    = 6,
    parameter int SID_W         = 3,
    parameter int ARB_RR        = 1,
    parameter int GRANT_TO      = 16,
    parameter int XFER_TO       = 1024,
    parameter int RETRY_HOLDOFF = 8
) (
    input logic                clk,
    input logic                rstn,
    param_bus_arbiter_if.slave bus
);
    localparam int GCNT_W    = $clog2(GRANT_TO + 1);
    localparam int XCNT_W    = $clog2(XFER_TO + 1);
    localparam int HCNT_W    = $clog2(RETRY_HOLDOFF + 1);
    localparam int BIT_W     = (SID_W > 1) ? $clog2(SID_W) : 1;
    localparam int LAST_BIT  = (SID_W > 1) ? SID_W - 2 : 0;
    localparam int SID_SPACE = 2**SID_W;
    localparam int MAX_M     = 2**MID_W;

    arb_state_e             r_state, w_state_next;
    logic [NUM_MASTERS-1:0] r_grants, w_grants_next;
    logic [NUM_SLAVES-1:0]  r_sel, w_sel_next;
    logic [MID_W-1:0]       r_winner, w_winner_next;
    logic [MID_W-1:0]       r_mid, w_mid_next;
    logic [MID_W-1:0]       r_rr_ptr, w_rr_ptr_next;
    logic [SID_W-1:0]       r_shift, w_shift_next;
    logic [SID_W-1:0]       r_sid, w_sid_next;
    logic [BIT_W-1:0]       r_bit_cnt, w_bit_cnt_next;
    logic [GCNT_W-1:0]      r_gnt_cnt, w_gnt_cnt_next;
    logic [XCNT_W-1:0]      r_xfer_cnt, w_xfer_cnt_next;
    logic                   r_timeout, w_timeout_next;

    logic                   w_holdoff_set;
    logic [NUM_MASTERS-1:0] w_eligible;
    logic [MID_W-1:0]       w_pick_idx;
    logic                   w_pick_valid;
    logic                   w_arb_rr;
    logic [SID_W-1:0]       w_shift_in;
    logic [SID_SPACE-1:0]   w_busy_pad;
    logic [MAX_M-1:0]       w_reqs_pad;
    logic                   w_winner_req;
    logic                   w_sid_ok;

    assign w_arb_rr     = (ARB_RR != 0);
    assign w_busy_pad   = SID_SPACE'(bus.slaves_busy);
    assign w_reqs_pad   = MAX_M'(bus.m_reqs);
    assign w_winner_req = w_reqs_pad[r_winner];
    assign w_shift_in   = (r_shift << 1) | SID_W'(bus.b_BUS);
    assign w_sid_ok     = ({1'b0, r_sid} < (SID_W+1)'(NUM_SLAVES)) && !w_busy_pad[r_sid];

    // A master that hit a busy or nonexistent slave sits out RETRY_HOLDOFF cycles.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_holdoff
            logic [HCNT_W-1:0] r_holdoff;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_holdoff <= '0;
                end else if (w_holdoff_set && (r_winner == MID_W'(gi))) begin
                    r_holdoff <= HCNT_W'(RETRY_HOLDOFF);
                end else if (r_holdoff != '0) begin
                    r_holdoff <= r_holdoff - 1'b1;
                end
            end
            assign w_eligible[gi] = bus.m_reqs[gi] && (r_holdoff == '0);
        end
    endgenerate

    arb_rr_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_picker (
        .i_eligible (w_eligible),
        .i_ptr      (r_rr_ptr),
        .i_arb_rr   (w_arb_rr),
        .o_winner   (w_pick_idx),
        .o_valid    (w_pick_valid)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_grants   <= '0;
            r_sel      <= '0;
            r_winner   <= '0;
            r_mid      <= '0;
            r_rr_ptr   <= '0;
            r_shift    <= '0;
            r_sid      <= '0;
            r_bit_cnt  <= '0;
            r_gnt_cnt  <= '0;
            r_xfer_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_grants   <= w_grants_next;
            r_sel      <= w_sel_next;
            r_winner   <= w_winner_next;
            r_mid      <= w_mid_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_shift    <= w_shift_next;
            r_sid      <= w_sid_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_gnt_cnt  <= w_gnt_cnt_next;
            r_xfer_cnt <= w_xfer_cnt_next;
            r_timeout  <= w_timeout_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_grants_next   = r_grants;
        w_sel_next      = r_sel;
        w_winner_next   = r_winner;
        w_mid_next      = r_mid;
        w_rr_ptr_next   = r_rr_ptr;
        w_shift_next    = r_shift;
        w_sid_next      = r_sid;
        w_bit_cnt_next  = r_bit_cnt;
        w_gnt_cnt_next  = r_gnt_cnt;
        w_xfer_cnt_next = r_xfer_cnt;
        w_timeout_next  = 1'b0;
        w_holdoff_set   = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_next   = GRANT;
                    w_winner_next  = w_pick_idx;
                    w_mid_next     = w_pick_idx;
                    w_grants_next  = NUM_MASTERS'(1) << w_pick_idx;
                    w_gnt_cnt_next = '0;
                end
            end
            GRANT: begin
                if (!w_winner_req) begin
                    w_state_next = RELEASE;
                end else if (!bus.b_bus_utilizing) begin
                    // The SID MSB is already on the line in the cycle utilisation drops.
                    w_shift_next   = SID_W'(bus.b_BUS);
                    w_bit_cnt_next = '0;
                    if (SID_W == 1) begin
                        w_sid_next   = SID_W'(bus.b_BUS);
                        w_state_next = CHECK;
                    end else begin
                        w_state_next = ADDR;
                    end
                end else if (r_gnt_cnt == GCNT_W'(GRANT_TO - 1)) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = RELEASE;
                end else begin
                    w_gnt_cnt_next = r_gnt_cnt + 1'b1;
                end
            end
            ADDR: begin
                if (bus.b_bus_utilizing) begin
                    w_state_next = RELEASE;
                end else begin
                    w_shift_next   = w_shift_in;
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == BIT_W'(LAST_BIT)) begin
                        w_sid_next   = w_shift_in;
                        w_state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                if (w_sid_ok) begin
                    w_sel_next      = NUM_SLAVES'(1) << r_sid;
                    w_xfer_cnt_next = '0;
                    w_state_next    = XFER;
                end else begin
                    w_holdoff_set = 1'b1;
                    w_state_next  = RELEASE;
                end
            end
            XFER: begin
                if (bus.b_bus_utilizing) begin
                    w_state_next = RELEASE;
                end else if (r_xfer_cnt == XCNT_W'(XFER_TO - 1)) begin
                    w_timeout_next = 1'b1;
                    w_state_next   = RELEASE;
                end else begin
                    w_xfer_cnt_next = r_xfer_cnt + 1'b1;
                end
            end
            RELEASE: begin
                w_state_next = IDLE;
                if (w_arb_rr) begin
                    w_rr_ptr_next = (r_winner == MID_W'(NUM_MASTERS - 1)) ? '0 : r_winner + 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase

        // Grant, select and grantee index all drop on the edge into RELEASE.
        if (w_state_next == RELEASE) begin
            w_grants_next = '0;
            w_sel_next    = '0;
            w_mid_next    = '0;
        end
    end

    assign bus.m_grants    = r_grants;
    assign bus.slaves_sel  = r_sel;
    assign bus.mid_current = r_mid;
    assign bus.sid_current = r_sid;
    assign bus.state       = r_state;
    assign bus.timeout_evt = r_timeout;

endmodule

// File: tb/tb_param_bus_arbiter.sv
// Self-checking bench: round-robin and fixed-priority arbiters driven by identical stimulus.
module tb_param_bus_arbiter;
    import bus_arb_pkg::*;

    localparam int NM = 12;
    localparam int NS = 6;
    localparam int SW = 3;

    typedef struct {
        logic [NM-1:0] reqs;
        logic [SW-1:0] sid;
        logic [NM-1:0] exp_rr;
        logic [NM-1:0] exp_fp;
        logic [NS-1:0] exp_sel;
    } vec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [NM-1:0] exp_q[$];
    vec_t vecs[4];

    always #5 clk = ~clk;

    param_bus_arbiter_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SID_W(SW)) bus ();
    param_bus_arbiter_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SID_W(SW)) bus_fp ();

    assign bus_fp.m_reqs          = bus.m_reqs;
    assign bus_fp.b_bus_utilizing = bus.b_bus_utilizing;
    assign bus_fp.b_BUS           = bus.b_BUS;
    assign bus_fp.slaves_busy     = bus.slaves_busy;

    param_bus_arbiter #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .SID_W(SW), .ARB_RR(1),
        .GRANT_TO(16), .XFER_TO(1024), .RETRY_HOLDOFF(8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    param_bus_arbiter #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .SID_W(SW), .ARB_RR(0),
        .GRANT_TO(16), .XFER_TO(1024), .RETRY_HOLDOFF(8)
    ) dut_fp (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_fp)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        while (bus.m_grants == '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.m_grants == '0) begin
            errors++;
            $display("FAIL %s: no grant within 50 cycles", name);
        end
    endtask

    // Called on the negedge where the grant is first visible; returns on the CHECK-state negedge.
    task automatic do_addr(input logic [SW-1:0] sid);
        bus.b_bus_utilizing = 1'b0;
        for (int b = SW - 1; b >= 0; b--) begin
            bus.b_BUS = sid[b];
            @(negedge clk);
        end
    endtask

    // Scoreboard: pops the expected winner on every rising grant, plus per-cycle invariants.
    initial begin
        logic [NM-1:0] prev;
        logic [NM-1:0] exp;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev = '0;
            end else begin
                if (prev == '0 && bus.m_grants != '0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected: got grant 0x%03h, required none", bus.m_grants);
                    end else begin
                        exp = exp_q.pop_front();
                        check("sb_grant", 32'(bus.m_grants), 32'(exp));
                        check("sb_mid", 32'(bus.mid_current), 32'(onehot_to_idx(16'(exp))));
                        $display("t=%0t grant 0x%03h mid=%0d (expected 0x%03h)",
                                 $time, bus.m_grants, bus.mid_current, exp);
                    end
                end
                check("inv_onehot_grant", 32'($countones(bus.m_grants) <= 1), 32'd1);
                check("inv_sel_only_xfer", 32'((bus.slaves_sel == '0) || (bus.state == XFER)), 32'd1);
                prev = bus.m_grants;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        logic [NS-1:0] sel_seen;

        vecs[0] = '{reqs: 12'h014, sid: 3'd0, exp_rr: 12'h010, exp_fp: 12'h004, exp_sel: 6'h01};
        vecs[1] = '{reqs: 12'h014, sid: 3'd5, exp_rr: 12'h004, exp_fp: 12'h004, exp_sel: 6'h20};
        vecs[2] = '{reqs: 12'h014, sid: 3'd2, exp_rr: 12'h010, exp_fp: 12'h004, exp_sel: 6'h04};
        vecs[3] = '{reqs: 12'h014, sid: 3'd1, exp_rr: 12'h004, exp_fp: 12'h004, exp_sel: 6'h02};

        bus.m_reqs          = '0;
        bus.b_bus_utilizing = 1'b1;
        bus.b_BUS           = 1'b0;
        bus.slaves_busy     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_grants", 32'(bus.m_grants), 32'd0);
        check("rst_sel", 32'(bus.slaves_sel), 32'd0);
        check("rst_mid", 32'(bus.mid_current), 32'd0);
        check("rst_sid", 32'(bus.sid_current), 32'd0);
        check("rst_state", 32'(bus.state), 32'(IDLE));
        check("rst_timeout", 32'(bus.timeout_evt), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_state", 32'(bus.state), 32'(IDLE));

        // 1. Single master, SID 3
        bus.m_reqs = 12'h004;
        exp_q.push_back(12'h004);
        @(negedge clk);
        check("t1_grant_latency", 32'(bus.m_grants), 32'h004);
        do_addr(3'b011);
        check("t1_state_check", 32'(bus.state), 32'(CHECK));
        check("t1_sid", 32'(bus.sid_current), 32'd3);
        @(negedge clk);
        check("t1_sel", 32'(bus.slaves_sel), 32'h08);
        check("t1_state_xfer", 32'(bus.state), 32'(XFER));
        repeat (5) @(negedge clk);
        check("t1_grant_held", 32'(bus.m_grants), 32'h004);
        bus.b_bus_utilizing = 1'b1;
        bus.m_reqs = '0;
        @(negedge clk);
        check("t1_rel_grants", 32'(bus.m_grants), 32'd0);
        check("t1_rel_sel", 32'(bus.slaves_sel), 32'd0);
        check("t1_rel_mid", 32'(bus.mid_current), 32'd0);
        check("t1_rel_state", 32'(bus.state), 32'(RELEASE));
        @(negedge clk);
        check("t1_back_idle", 32'(bus.state), 32'(IDLE));

        // 2. Round-robin vs fixed priority with masters 2 and 4 both requesting
        for (int r = 0; r < 4; r++) begin
            bus.m_reqs = vecs[r].reqs;
            exp_q.push_back(vecs[r].exp_rr);
            wait_grant("t2_wait");
            check("t2_fp_grant", 32'(bus_fp.m_grants), 32'(vecs[r].exp_fp));
            do_addr(vecs[r].sid);
            @(negedge clk);
            check("t2_rr_sel", 32'(bus.slaves_sel), 32'(vecs[r].exp_sel));
            check("t2_fp_sel", 32'(bus_fp.slaves_sel), 32'(vecs[r].exp_sel));
            repeat (15) @(negedge clk);
            bus.b_bus_utilizing = 1'b1;
            if (r == 3) bus.m_reqs = '0;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // 3. Busy slave abort, then master 2 served while master 4 is held off
        bus.slaves_busy = 6'h10;
        bus.m_reqs = 12'h010;
        exp_q.push_back(12'h010);
        wait_grant("t3_wait4");
        do_addr(3'd4);
        bus.b_bus_utilizing = 1'b1;
        @(negedge clk);
        check("t3_abort_grants", 32'(bus.m_grants), 32'd0);
        check("t3_abort_sel", 32'(bus.slaves_sel), 32'd0);
        check("t3_abort_state", 32'(bus.state), 32'(RELEASE));
        bus.m_reqs = 12'h014;
        exp_q.push_back(12'h004);
        wait_grant("t3_wait2");
        do_addr(3'd1);
        @(negedge clk);
        check("t3_m2_sel", 32'(bus.slaves_sel), 32'h02);
        repeat (10) @(negedge clk);
        bus.b_bus_utilizing = 1'b1;
        bus.m_reqs = 12'h010;
        exp_q.push_back(12'h010);
        @(negedge clk);
        wait_grant("t3_regrant4");
        check("t3_m4_regrant", 32'(bus.m_grants), 32'h010);
        bus.m_reqs = '0;
        bus.slaves_busy = '0;
        repeat (3) @(negedge clk);
        check("t3_req_drop_idle", 32'(bus.state), 32'(IDLE));

        // 4. Grant watchdog: utilisation never asserted
        bus.m_reqs = 12'h001;
        exp_q.push_back(12'h001);
        wait_grant("t4_wait");
        n = 0;
        pulses = 0;
        for (int k = 0; k < 40 && bus.m_grants != '0; k++) begin
            n++;
            if (bus.timeout_evt) pulses++;
            @(negedge clk);
        end
        check("t4_grant_cycles", 32'(n), 32'd16);
        check("t4_evt_at_drop", 32'(bus.timeout_evt), 32'd1);
        bus.m_reqs = '0;
        repeat (6) begin
            if (bus.timeout_evt) pulses++;
            @(negedge clk);
        end
        check("t4_evt_pulses", 32'(pulses), 32'd1);

        // 5. Invalid SID: abort, no select, re-grant after RETRY_HOLDOFF+1 idle cycles
        bus.m_reqs = 12'h002;
        exp_q.push_back(12'h002);
        wait_grant("t5_wait");
        do_addr(3'b111);
        check("t5_sid", 32'(bus.sid_current), 32'd7);
        bus.b_bus_utilizing = 1'b1;
        exp_q.push_back(12'h002);
        sel_seen = bus.slaves_sel;
        n = 0;
        @(negedge clk);
        while (bus.m_grants == '0 && n < 40) begin
            n++;
            sel_seen |= bus.slaves_sel;
            @(negedge clk);
        end
        check("t5_holdoff_gap", 32'(n), 32'd9);
        check("t5_no_sel", 32'(sel_seen), 32'd0);
        check("t5_regrant", 32'(bus.m_grants), 32'h002);
        bus.m_reqs = '0;
        repeat (3) @(negedge clk);

        // 6. Asynchronous reset mid-transfer
        bus.m_reqs = 12'h008;
        exp_q.push_back(12'h008);
        wait_grant("t6_wait");
        do_addr(3'd2);
        @(negedge clk);
        check("t6_sel", 32'(bus.slaves_sel), 32'h04);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("t6_async_grants", 32'(bus.m_grants), 32'd0);
        check("t6_async_sel", 32'(bus.slaves_sel), 32'd0);
        check("t6_async_mid", 32'(bus.mid_current), 32'd0);
        check("t6_async_state", 32'(bus.state), 32'(IDLE));
        bus.b_bus_utilizing = 1'b1;
        @(negedge clk);
        exp_q.push_back(12'h008);
        rstn = 1'b1;
        wait_grant("t6_after_reset");
        check("t6_regrant", 32'(bus.m_grants), 32'h008);
        do_addr(3'd0);
        @(negedge clk);
        check("t6_sel_after_reset", 32'(bus.slaves_sel), 32'h01);
        bus.b_bus_utilizing = 1'b1;
        bus.m_reqs = '0;
        repeat (3) @(negedge clk);
        check("t6_final_idle", 32'(bus.state), 32'(IDLE));

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
